alu_arbiter: RTL and testbench

- Shares the single combinational ALU instance between two requesters: requester 0 is the core execute path, requester 1 is the debug/lookup helper.
- Accepts one operation at a time through a valid/ready handshake and registers operands.
- Runs the ALU for one cycle, then holds the registered result and jump flag until the owning requester accepts it.
- Grant order is round-robin, so neither requester starves.

---
 rtl/alu_arbiter_pkg.sv | 46 ++++
 rtl/alu_arbiter_alu.sv | 48 ++++
 rtl/alu_arbiter.sv | 172 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter_pkg
//  Description : Shared definitions for the ALU arbiter slice: opcode
//                mnemonics, arbiter FSM state type and the opcode legality
//                helper.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_arbiter_pkg;

   localparam int OP_W = 4;

   // Opcode mnemonics. Encodings 10..15 are unused and reported as errors.
   //   kXOR : logical xor of (A != 0) and (B != 0), result 0 or 1
   //   kXXR : parity (reduction xor) of A ^ B, result 0 or 1
   typedef enum logic [OP_W-1:0] {
      kADD = 4'd0,
      kXOR = 4'd1,
      kORR = 4'd2,
      kBEQ = 4'd3,
      kBNE = 4'd4,
      kSLL = 4'd5,
      kSRL = 4'd6,
      kXXR = 4'd7,
      kSUB = 4'd8,
      kAND = 4'd9
   } op_mne;

   typedef enum logic [1:0] {
      IDLE_S = 2'd0,
      EXEC_S = 2'd1,
      RESP_S = 2'd2
   } arb_state_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      logic legal;
      case (op)
         kADD, kXOR, kORR, kBEQ, kBNE,
         kSLL, kSRL, kXXR, kSUB, kAND: legal = 1'b1;
         default:                      legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
//  Module      : ALU
//  Description : Purely combinational ALU. Out is the op_mne result at width
//                W; Jump flags a non-zero result. Unused opcodes give 0.
//  Ports       : A, B  [W-1:0]   operands
//                Op    [Ops-1:0] opcode (op_mne encoding)
//                Out   [W-1:0]   result
//                Jump            Out != 0
//  Revision    : 1.0  initial release
// ============================================================================
module ALU
   import alu_arbiter_pkg::*;
#(
   parameter int W   = 8,
   parameter int Ops = 4
) (
   input  logic [W-1:0]   A,
   input  logic [W-1:0]   B,
   input  logic [Ops-1:0] Op,
   output logic [W-1:0]   Out,
   output logic           Jump
);

   localparam logic [W-2:0] c_zpad = '0;

   always_comb begin
      Out = '0;
      case (Op)
         kADD: Out = A + B;
         kSUB: Out = A - B;
         kORR: Out = A | B;
         kAND: Out = A & B;
         kXOR: Out = {c_zpad, (|A) ^ (|B)};
         kXXR: Out = {c_zpad, ^(A ^ B)};
         kBEQ: Out = {c_zpad, A == B};
         kBNE: Out = {c_zpad, A != B};
         // Shift amount is the whole B value, so B >= W clears the result.
         kSLL: Out = A << B;
         kSRL: Out = A >> B;
         default: Out = '0;
      endcase
   end

   assign Jump = |Out;

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one combinational ALU between two requesters
//                (0 = core execute path, 1 = debug/lookup helper). One
//                operation in flight; round-robin grant between requesters.
//                IDLE -> EXEC (one cycle, ALU evaluated) -> RESP (held until
//                the owner accepts).
//  Ports       : Clk, Reset_n          clock / async active-low reset
//                ReqValid/ReqReady[1:0] request handshake, bit i = requester i
//                ReqOpN, ReqAN, ReqBN   per-requester opcode and operands
//                RspValid[1:0]          one-hot to the owning requester
//                RspReady[1:0]          response accept, owner bit only
//                RspData, RspJump       registered ALU result / jump flag
//                RspErr                 opcode was not a legal op_mne
//                Busy                   FSM not in IDLE
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int W   = 8,
   parameter int Ops = 4
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic [1:0]     ReqValid,
   output logic [1:0]     ReqReady,
   input  logic [Ops-1:0] ReqOp0,
   input  logic [Ops-1:0] ReqOp1,
   input  logic [W-1:0]   ReqA0,
   input  logic [W-1:0]   ReqA1,
   input  logic [W-1:0]   ReqB0,
   input  logic [W-1:0]   ReqB1,
   output logic [1:0]     RspValid,
   input  logic [1:0]     RspReady,
   output logic [W-1:0]   RspData,
   output logic           RspJump,
   output logic           RspErr,
   output logic           Busy
);

   arb_state_t     r_state;
   arb_state_t     w_next_state;

   logic           r_ptr;
   logic           r_owner;
   logic [Ops-1:0] r_op;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic [W-1:0]   r_data;
   logic           r_jump;
   logic           r_err;

   logic           w_grant_id;
   logic           w_accept;
   logic           w_rsp_done;
   logic           w_op_legal;
   logic [W-1:0]   w_alu_out;
   logic           w_alu_jump;

   // ALU sees only the operand registers, so request ports may change freely
   // once the operation is accepted.
   ALU #(
      .W   (W),
      .Ops (Ops)
   ) u_alu (
      .A    (r_a),
      .B    (r_b),
      .Op   (r_op),
      .Out  (w_alu_out),
      .Jump (w_alu_jump)
   );

   assign w_op_legal = is_legal_op(r_op);

   // A lone requester always wins; on contention the pointer decides.
   always_comb begin
      w_grant_id = r_ptr;
      if (ReqValid == 2'b01) begin
         w_grant_id = 1'b0;
      end else if (ReqValid == 2'b10) begin
         w_grant_id = 1'b1;
      end
   end

   assign w_accept   = (r_state == IDLE_S) && (|ReqValid);
   assign w_rsp_done = (r_state == RESP_S) && RspReady[r_owner];

   // ---------------------------------------------------------------- state
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE_S;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE_S:  if (w_accept)   w_next_state = EXEC_S;
         EXEC_S:                  w_next_state = RESP_S;
         RESP_S:  if (w_rsp_done) w_next_state = IDLE_S;
         default:                 w_next_state = IDLE_S;
      endcase
   end

   // -------------------------------------------------------------- outputs
   // ReqReady is a combinational path from ReqValid; it is also qualified by
   // Reset_n so it reads 0 while reset is held, whatever ReqValid does.
   always_comb begin
      ReqReady = 2'b00;
      RspValid = 2'b00;
      Busy     = (r_state != IDLE_S);
      if (Reset_n && (r_state == IDLE_S) && (|ReqValid)) begin
         ReqReady[w_grant_id] = 1'b1;
      end
      if (r_state == RESP_S) begin
         RspValid[r_owner] = 1'b1;
      end
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_ptr   <= 1'b0;
         r_owner <= 1'b0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_data  <= '0;
         r_jump  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_owner <= w_grant_id;
            if (w_grant_id) begin
               r_op <= ReqOp1;
               r_a  <= ReqA1;
               r_b  <= ReqB1;
            end else begin
               r_op <= ReqOp0;
               r_a  <= ReqA0;
               r_b  <= ReqB0;
            end
         end
         if (r_state == EXEC_S) begin
            // Illegal opcodes return a clean zero rather than ALU output.
            if (w_op_legal) begin
               r_data <= w_alu_out;
               r_jump <= w_alu_jump;
               r_err  <= 1'b0;
            end else begin
               r_data <= '0;
               r_jump <= 1'b0;
               r_err  <= 1'b1;
            end
         end
         if (w_rsp_done) begin
            r_ptr <= ~r_owner;
         end
      end
   end

   assign RspData = r_data;
   assign RspJump = r_jump;
   assign RspErr  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter. Directed cases followed
//                by randomized transactions, compared against a behavioural
//                reference (integer arithmetic + round-robin pointer model).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic [1:0] ReqValid;
   logic [1:0] ReqReady;
   logic [3:0] ReqOp0, ReqOp1;
   logic [7:0] ReqA0, ReqA1, ReqB0, ReqB1;
   logic [1:0] RspValid;
   logic [1:0] RspReady;
   logic [7:0] RspData;
   logic       RspJump;
   logic       RspErr;
   logic       Busy;

   int n_checks = 0;
   int n_errors = 0;
   logic m_ptr;

   alu_arbiter #(.W(8), .Ops(4)) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .ReqValid (ReqValid),
      .ReqReady (ReqReady),
      .ReqOp0   (ReqOp0),
      .ReqOp1   (ReqOp1),
      .ReqA0    (ReqA0),
      .ReqA1    (ReqA1),
      .ReqB0    (ReqB0),
      .ReqB1    (ReqB1),
      .RspValid (RspValid),
      .RspReady (RspReady),
      .RspData  (RspData),
      .RspJump  (RspJump),
      .RspErr   (RspErr),
      .Busy     (Busy)
   );

   always #5 Clk = ~Clk;

   initial begin
      #400000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Reference: returns {err, jump, data[7:0]} from plain integer arithmetic.
   function automatic logic [9:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      int ai = a;
      int bi = b;
      int r  = 0;
      int ones;
      logic err = 1'b0;
      case (op)
         4'd0: r = (ai + bi) % 256;
         4'd8: r = (ai - bi + 256) % 256;
         4'd1: r = ((ai != 0) != (bi != 0)) ? 1 : 0;
         4'd2: r = ai | bi;
         4'd9: r = ai & bi;
         4'd3: r = (ai == bi) ? 1 : 0;
         4'd4: r = (ai != bi) ? 1 : 0;
         4'd5: r = (bi >= 8) ? 0 : (ai * (2 ** bi)) % 256;
         4'd6: r = (bi >= 8) ? 0 : ai / (2 ** bi);
         4'd7: begin
            ones = 0;
            for (int k = 0; k < 8; k++) ones += ((ai ^ bi) >> k) & 1;
            r = ones % 2;
         end
         default: begin r = 0; err = 1'b1; end
      endcase
      return {err, (r != 0), r[7:0]};
   endfunction

   // Entered and left at posedge+1 with the DUT idle.
   task automatic do_txn(input logic [1:0] v,
                         input logic [3:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic [3:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                         input int hold);
      logic       g;
      logic [9:0] e;
      logic [1:0] own;
      ReqValid = v; RspReady = 2'b00;
      ReqOp0 = op0; ReqA0 = a0; ReqB0 = b0;
      ReqOp1 = op1; ReqA1 = a1; ReqB1 = b1;
      g   = (v == 2'b11) ? m_ptr : (v == 2'b10);
      own = g ? 2'b10 : 2'b01;
      #1;
      chk("idle_reqready", ReqReady, (v == 2'b00) ? 2'b00 : own);
      chk("idle_busy", Busy, 0);
      chk("idle_rspvalid", RspValid, 0);
      @(posedge Clk); #1;
      if (v == 2'b00) return;
      e = g ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
      // Scramble request ports: result must come from captured operands.
      ReqValid = 2'($urandom);
      ReqOp0 = 4'($urandom); ReqA0 = 8'($urandom); ReqB0 = 8'($urandom);
      ReqOp1 = 4'($urandom); ReqA1 = 8'($urandom); ReqB1 = 8'($urandom);
      #1;
      chk("exec_busy", Busy, 1);
      chk("exec_reqready", ReqReady, 0);
      chk("exec_rspvalid", RspValid, 0);
      @(posedge Clk); #1;
      for (int i = 0; i <= hold; i++) begin
         ReqValid = 2'($urandom);
         if (g) RspReady = {(i == hold), 1'($urandom)};
         else   RspReady = {1'($urandom), (i == hold)};
         #1;
         chk("resp_rspvalid", RspValid, own);
         chk("resp_data", RspData, e[7:0]);
         chk("resp_jump", RspJump, e[8]);
         chk("resp_err", RspErr, e[9]);
         chk("resp_reqready", ReqReady, 0);
         @(posedge Clk); #1;
      end
      ReqValid = 2'b00; RspReady = 2'b00;
      #1;
      chk("done_rspvalid", RspValid, 0);
      chk("done_busy", Busy, 0);
      m_ptr = ~g;
   endtask

   // Starts a contended request, then pulses reset in EXEC (phase 0) or RESP (1).
   task automatic rst_during(input int phase);
      ReqValid = 2'b11; RspReady = 2'b00;
      ReqOp0 = 4'd0; ReqA0 = 8'h11; ReqB0 = 8'h22;
      ReqOp1 = 4'd0; ReqA1 = 8'h33; ReqB1 = 8'h44;
      @(posedge Clk); #1;
      if (phase == 1) begin
         @(posedge Clk); #1;
         chk("pre_rst_rspvalid", RspValid, m_ptr ? 2'b10 : 2'b01);
      end
      #1 Reset_n = 1'b0;
      #1;
      chk("rst_rspvalid", RspValid, 0);
      chk("rst_reqready", ReqReady, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_data", RspData, 0);
      chk("rst_jump", RspJump, 0);
      chk("rst_err", RspErr, 0);
      @(negedge Clk);
      ReqValid = 2'b00;
      Reset_n  = 1'b1;
      m_ptr    = 1'b0;
      @(posedge Clk); #1;
      chk("post_rst_rspvalid", RspValid, 0);
   endtask

   initial begin
      logic [3:0] r_op0, r_op1;
      logic [7:0] r_b0, r_b1;
      Reset_n = 1'b0; ReqValid = 2'b00; RspReady = 2'b00;
      ReqOp0 = '0; ReqOp1 = '0; ReqA0 = '0; ReqA1 = '0; ReqB0 = '0; ReqB1 = '0;
      m_ptr = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_rspvalid", RspValid, 0);
      chk("reset_data", RspData, 0);
      chk("reset_busy", Busy, 0);
      Reset_n = 1'b1;
      @(posedge Clk); #1;

      do_txn(2'b01, 4'd0, 8'h05, 8'h03, 4'd0, 8'h00, 8'h00, 0);   // ADD -> 08
      do_txn(2'b10, 4'd0, 8'h00, 8'h00, 4'd8, 8'h03, 8'h05, 4);   // SUB -> FE
      for (int i = 0; i < 4; i++)
         do_txn(2'b11, 4'd3, 8'h2A, 8'h2A, 4'd0, 8'(i), 8'h10, 0);
      do_txn(2'b01, 4'd5, 8'h81, 8'h01, 4'd0, 8'h00, 8'h00, 0);   // SLL -> 02
      do_txn(2'b10, 4'd0, 8'h00, 8'h00, 4'd6, 8'h80, 8'h09, 1);   // SRL -> 00
      do_txn(2'b01, 4'hC, 8'h12, 8'h34, 4'd0, 8'h00, 8'h00, 0);   // illegal
      do_txn(2'b01, 4'd0, 8'h05, 8'h03, 4'd0, 8'h00, 8'h00, 0);   // ptr -> 1
      rst_during(0);
      do_txn(2'b11, 4'd2, 8'hF0, 8'h0F, 4'd9, 8'hFF, 8'h0F, 0);   // owner 0
      rst_during(1);
      do_txn(2'b11, 4'd7, 8'h03, 8'h01, 4'd4, 8'h01, 8'h01, 0);   // owner 0

      for (int n = 0; n < 80; n++) begin
         r_op0 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         r_op1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
         r_b0  = $urandom_range(0, 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
         r_b1  = $urandom_range(0, 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
         do_txn(2'($urandom), r_op0, 8'($urandom), r_b0, r_op1, 8'($urandom), r_b1,
                int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
